// File: rtl/vec_regfile_seq.sv
// vec_regfile_seq: vector register file whose LMUL groups move one VLEN beat per cycle over read/write bursts.
// Optional RD_BYPASS_EN: a read beat sampling a register written at the same edge returns the new data.
module vec_regfile_seq #(
    parameter int VLEN          = 512,
    parameter int NUM_REGS      = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int MAX_LMUL_LOG2 = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_rd_req_valid,
    output logic                  o_rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr1,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr2,
    input  logic [1:0]            i_rd_lmul,
    output logic                  o_rd_valid,
    output logic [VLEN-1:0]       o_rdata_1,
    output logic [VLEN-1:0]       o_rdata_2,
    output logic [2:0]            o_rd_beat,
    output logic                  o_rd_last,
    output logic                  o_rd_err,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [1:0]            i_wr_lmul,
    input  logic [VLEN-1:0]       i_wdata,
    output logic                  o_wr_done,
    output logic                  o_wr_err,
    input  logic                  i_mask_wr_en,
    input  logic [VLEN-1:0]       i_mask_wdata,
    output logic [VLEN-1:0]       o_v0_mask_data
);
    localparam int CW = MAX_LMUL_LOG2 + 1;
    localparam logic [0:0] RIDLE  = 1'b0;
    localparam logic [0:0] RBURST = 1'b1;
    localparam logic [1:0] WIDLE  = 2'd0;
    localparam logic [1:0] WBURST = 2'd1;
    localparam logic [1:0] WDRAIN = 2'd2;

    logic [VLEN-1:0]       r_regs [NUM_REGS];
    logic [0:0]            r_rstate;
    logic [ADDR_WIDTH-1:0] r_raddr1, r_raddr2;
    logic [CW-1:0]         r_rk, r_rlast_k;
    logic [1:0]            r_wstate;
    logic [ADDR_WIDTH-1:0] r_wbase;
    logic [CW-1:0]         r_wk, r_wlast_k;

    logic                  w_rd_acc, w_rd_legal, w_wr_acc, w_wr_legal, w_we;
    logic [CW-1:0]         w_rk_next, w_wr_first_last_k;
    logic [ADDR_WIDTH-1:0] w_ridx1, w_ridx2, w_widx;
    logic [VLEN-1:0]       w_wdat, w_rnext1, w_rnext2;

    function automatic logic f_legal(input logic [ADDR_WIDTH-1:0] base, input logic [1:0] lmul);
        int l;
        l = 1 << lmul;
        return (int'(lmul) <= MAX_LMUL_LOG2) && (int'(base) % l == 0) && (int'(base) + l <= NUM_REGS);
    endfunction

    // Index of the final beat; oversized LMUL drains the largest legal group minus beat 0.
    function automatic logic [CW-1:0] f_last_k(input logic [1:0] lmul);
        return (int'(lmul) > MAX_LMUL_LOG2) ? CW'((1 << MAX_LMUL_LOG2) - 1) : CW'((1 << lmul) - 1);
    endfunction

    assign o_rd_req_ready    = (r_rstate == RIDLE);
    assign o_wr_ready        = !i_mask_wr_en;
    assign o_v0_mask_data    = r_regs[0];
    assign w_rd_acc          = i_rd_req_valid && (r_rstate == RIDLE);
    assign w_rd_legal        = f_legal(i_rd_addr1, i_rd_lmul) && f_legal(i_rd_addr2, i_rd_lmul);
    assign w_rk_next         = r_rk + 1'b1;
    assign w_ridx1           = (r_rstate == RIDLE) ? i_rd_addr1 : r_raddr1 + ADDR_WIDTH'(w_rk_next);
    assign w_ridx2           = (r_rstate == RIDLE) ? i_rd_addr2 : r_raddr2 + ADDR_WIDTH'(w_rk_next);
    assign w_wr_acc          = i_wr_valid && !i_mask_wr_en;
    assign w_wr_legal        = f_legal(i_wr_addr, i_wr_lmul);
    assign w_wr_first_last_k = f_last_k(i_wr_lmul);
    assign w_we   = i_mask_wr_en || (w_wr_acc && ((r_wstate == WIDLE) ? w_wr_legal : (r_wstate == WBURST)));
    assign w_widx = i_mask_wr_en ? '0 : ((r_wstate == WIDLE) ? i_wr_addr : r_wbase + ADDR_WIDTH'(r_wk));
    assign w_wdat = i_mask_wr_en ? i_mask_wdata : i_wdata;

`ifdef RD_BYPASS_EN
    assign w_rnext1 = (w_we && (w_widx == w_ridx1)) ? w_wdat : r_regs[w_ridx1];
    assign w_rnext2 = (w_we && (w_widx == w_ridx2)) ? w_wdat : r_regs[w_ridx2];
`else
    assign w_rnext1 = r_regs[w_ridx1];
    assign w_rnext2 = r_regs[w_ridx2];
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_we) begin
            r_regs[w_widx] <= w_wdat;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rstate   <= RIDLE;
            r_raddr1   <= '0;
            r_raddr2   <= '0;
            r_rk       <= '0;
            r_rlast_k  <= '0;
            o_rd_valid <= 1'b0;
            o_rdata_1  <= '0;
            o_rdata_2  <= '0;
            o_rd_beat  <= '0;
            o_rd_last  <= 1'b0;
            o_rd_err   <= 1'b0;
        end else begin
            o_rd_err <= 1'b0;
            if (r_rstate == RIDLE) begin
                if (w_rd_acc && w_rd_legal) begin
                    r_rstate   <= RBURST;
                    r_raddr1   <= i_rd_addr1;
                    r_raddr2   <= i_rd_addr2;
                    r_rk       <= '0;
                    r_rlast_k  <= f_last_k(i_rd_lmul);
                    o_rd_valid <= 1'b1;
                    o_rd_beat  <= '0;
                    o_rd_last  <= (i_rd_lmul == 2'd0);
                    o_rdata_1  <= w_rnext1;
                    o_rdata_2  <= w_rnext2;
                end else begin
                    o_rd_err <= w_rd_acc;
                end
            end else if (r_rk == r_rlast_k) begin
                r_rstate   <= RIDLE;
                o_rd_valid <= 1'b0;
                o_rd_beat  <= '0;
                o_rd_last  <= 1'b0;
            end else begin
                r_rk      <= w_rk_next;
                o_rd_beat <= 3'(w_rk_next);
                o_rd_last <= (w_rk_next == r_rlast_k);
                o_rdata_1 <= w_rnext1;
                o_rdata_2 <= w_rnext2;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wstate  <= WIDLE;
            r_wbase   <= '0;
            r_wk      <= '0;
            r_wlast_k <= '0;
            o_wr_done <= 1'b0;
            o_wr_err  <= 1'b0;
        end else begin
            o_wr_done <= 1'b0;
            o_wr_err  <= 1'b0;
            if (w_wr_acc) begin
                if (r_wstate == WIDLE) begin
                    r_wbase   <= i_wr_addr;
                    r_wk      <= CW'(1);
                    r_wlast_k <= w_wr_first_last_k;
                    o_wr_err  <= !w_wr_legal;
                    o_wr_done <= w_wr_legal && (w_wr_first_last_k == '0);
                    r_wstate  <= (w_wr_first_last_k == '0) ? WIDLE : (w_wr_legal ? WBURST : WDRAIN);
                end else begin
                    r_wk <= r_wk + 1'b1;
                    if (r_wk == r_wlast_k) begin
                        r_wstate  <= WIDLE;
                        o_wr_done <= (r_wstate == WBURST);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_regfile_seq.sv
// tb_vec_regfile_seq: directed scenarios plus randomized traffic checked against a queue-based model of vec_regfile_seq.
module tb_vec_regfile_seq;
    localparam int VLEN = 512;
    localparam int NUM_REGS = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int MAX_LMUL_LOG2 = 3;

    typedef struct {
        int a1;
        int a2;
        int k;
    } rbeat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rd_req_valid, rd_req_ready, rd_valid, rd_last, rd_err;
    logic [ADDR_WIDTH-1:0] rd_addr1, rd_addr2, wr_addr;
    logic [1:0] rd_lmul, wr_lmul;
    logic [VLEN-1:0] rdata_1, rdata_2, wdata, mask_wdata, v0_mask_data;
    logic [2:0] rd_beat;
    logic wr_valid, wr_ready, wr_done, wr_err, mask_wr_en;

    int checks = 0;
    int errors = 0;

    logic [VLEN-1:0] m_reg [NUM_REGS];
    rbeat_t rq[$];
    int wq[$];
    bit e_rd_valid, e_last, e_rd_err, e_wr_done, e_wr_err;
    int e_beat;
    logic [VLEN-1:0] e_rdata1, e_rdata2, va, vb, vexp;

    vec_regfile_seq #(
        .VLEN(VLEN), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH), .MAX_LMUL_LOG2(MAX_LMUL_LOG2)
    ) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_rd_req_valid(rd_req_valid), .o_rd_req_ready(rd_req_ready),
        .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2), .i_rd_lmul(rd_lmul),
        .o_rd_valid(rd_valid), .o_rdata_1(rdata_1), .o_rdata_2(rdata_2),
        .o_rd_beat(rd_beat), .o_rd_last(rd_last), .o_rd_err(rd_err),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_lmul(wr_lmul),
        .i_wdata(wdata), .o_wr_done(wr_done), .o_wr_err(wr_err),
        .i_mask_wr_en(mask_wr_en), .i_mask_wdata(mask_wdata), .o_v0_mask_data(v0_mask_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input int base, input int lmul);
        int l;
        l = 1 << lmul;
        return lmul <= MAX_LMUL_LOG2 && base % l == 0 && base + l <= NUM_REGS;
    endfunction

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] v;
        for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic rand_addr(output logic [ADDR_WIDTH-1:0] a, input logic [1:0] lm);
        a = ADDR_WIDTH'($urandom_range(0, NUM_REGS - 1));
        if ($urandom_range(0, 9) < 8) a = a & ~ADDR_WIDTH'((1 << lm) - 1);
    endtask

    task automatic idle_inputs();
        rd_req_valid = 0; rd_addr1 = '0; rd_addr2 = '0; rd_lmul = '0;
        wr_valid = 0; wr_addr = '0; wr_lmul = '0; wdata = '0;
        mask_wr_en = 0; mask_wdata = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_reg[i] = '0;
        rq.delete();
        wq.delete();
        e_rd_valid = 0; e_last = 0; e_rd_err = 0; e_wr_done = 0; e_wr_err = 0; e_beat = 0;
        e_rdata1 = '0; e_rdata2 = '0;
    endtask

    // Pending write targets live in wq (-1 = discarded drain beat); pending read beats in rq.
    task automatic model_step();
        int l, t, n, w_idx;
        bit w_en, n_done, n_werr, n_rerr;
        logic [VLEN-1:0] w_dat;
        rbeat_t b;
        w_en = 0; w_idx = 0; w_dat = '0; n_done = 0; n_werr = 0; n_rerr = 0;
        if (mask_wr_en) begin
            w_en = 1; w_idx = 0; w_dat = mask_wdata;
        end else if (wr_valid) begin
            if (wq.size() == 0) begin
                l = 1 << wr_lmul;
                if (legal(int'(wr_addr), int'(wr_lmul))) begin
                    w_en = 1; w_idx = int'(wr_addr); w_dat = wdata; n_done = (l == 1);
                    for (int k = 1; k < l; k++) wq.push_back(int'(wr_addr) + k);
                end else begin
                    n_werr = 1;
                    n = ((int'(wr_lmul) > MAX_LMUL_LOG2) ? (1 << MAX_LMUL_LOG2) : l) - 1;
                    repeat (n) wq.push_back(-1);
                end
            end else begin
                t = wq.pop_front();
                if (t >= 0) begin
                    w_en = 1; w_idx = t; w_dat = wdata; n_done = (wq.size() == 0);
                end
            end
        end
        if (!e_rd_valid && rd_req_valid) begin
            l = 1 << rd_lmul;
            if (legal(int'(rd_addr1), int'(rd_lmul)) && legal(int'(rd_addr2), int'(rd_lmul))) begin
                for (int k = 0; k < l; k++) begin
                    b.a1 = int'(rd_addr1) + k; b.a2 = int'(rd_addr2) + k; b.k = k;
                    rq.push_back(b);
                end
            end else n_rerr = 1;
        end
        if (rq.size() > 0) begin
            b = rq.pop_front();
            e_rd_valid = 1; e_beat = b.k; e_last = (rq.size() == 0);
`ifdef RD_BYPASS_EN
            e_rdata1 = (w_en && w_idx == b.a1) ? w_dat : m_reg[b.a1];
            e_rdata2 = (w_en && w_idx == b.a2) ? w_dat : m_reg[b.a2];
`else
            e_rdata1 = m_reg[b.a1];
            e_rdata2 = m_reg[b.a2];
`endif
        end else begin
            e_rd_valid = 0; e_beat = 0; e_last = 0;
        end
        if (w_en) m_reg[w_idx] = w_dat;
        e_wr_done = n_done; e_wr_err = n_werr; e_rd_err = n_rerr;
    endtask

    // Inputs are set at the falling edge before calling; returns at the next falling edge.
    task automatic cycle();
        #1;
        check("rd_req_ready", rd_req_ready, !e_rd_valid);
        check("wr_ready", wr_ready, !mask_wr_en);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("rd_valid", rd_valid, e_rd_valid);
        check("rd_beat", rd_beat, e_beat);
        check("rd_last", rd_last, e_last);
        check("rd_err", rd_err, e_rd_err);
        check("wr_done", wr_done, e_wr_done);
        check("wr_err", wr_err, e_wr_err);
        check("v0_mask_data", v0_mask_data, m_reg[0]);
        if (e_rd_valid) begin
            check("rdata_1", rdata_1, e_rdata1);
            check("rdata_2", rdata_2, e_rdata2);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_req_ready"}, rd_req_ready, 1);
        check({tag, "_wr_ready"}, wr_ready, 1);
        check({tag, "_rd_last"}, rd_last, 0);
        check({tag, "_rd_beat"}, rd_beat, 0);
        check({tag, "_rd_err"}, rd_err, 0);
        check({tag, "_wr_done"}, wr_done, 0);
        check({tag, "_wr_err"}, wr_err, 0);
        check({tag, "_rdata_1"}, rdata_1, 0);
        check({tag, "_v0"}, v0_mask_data, 0);
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1;

        rd_req_valid = 1; rd_addr1 = 8; rd_addr2 = 16; rd_lmul = 0;
        cycle();
        rd_req_valid = 0;
        check("t1_valid", rd_valid, 1);
        check("t1_last", rd_last, 1);
        check("t1_beat", rd_beat, 0);
        check("t1_rdata_1", rdata_1, 0);
        check("t1_rdata_2", rdata_2, 0);
        cycle();

        for (int k = 0; k < 4; k++) begin
            wr_valid = 1; wr_addr = 8; wr_lmul = 2; wdata = VLEN'(17 * (k + 1));
            cycle();
            check("t2_wr_done", wr_done, k == 3);
        end
        wr_valid = 0;
        rd_req_valid = 1; rd_addr1 = 8; rd_addr2 = 8; rd_lmul = 2;
        cycle();
        rd_req_valid = 0;
        for (int k = 0; k < 4; k++) begin
            check("t2_rdata", rdata_1, VLEN'(17 * (k + 1)));
            check("t2_beat", rd_beat, k);
            check("t2_last", rd_last, k == 3);
            cycle();
        end

        for (int k = 0; k < 4; k++) begin
            wr_valid = 1; wr_addr = 6; wr_lmul = 2; wdata = rand_vec();
            cycle();
            check("t3_wr_err", wr_err, k == 0);
            check("t3_wr_done", wr_done, 0);
        end
        wr_valid = 0;
        rd_req_valid = 1; rd_addr1 = 4; rd_addr2 = 8; rd_lmul = 2;
        cycle();
        rd_req_valid = 0;
        repeat (4) cycle();
        rd_req_valid = 1; rd_addr1 = 0; rd_addr2 = 30; rd_lmul = 2;
        cycle();
        rd_req_valid = 0;
        check("t3_rd_err", rd_err, 1);
        check("t3_rd_valid", rd_valid, 0);
        cycle();

        va = rand_vec(); vb = rand_vec();
        wr_valid = 1; wr_addr = 0; wr_lmul = 1; wdata = va;
        mask_wr_en = 1; mask_wdata = VLEN'(16'hF0F0);
        #1 check("t4_wr_ready", wr_ready, 0);
        cycle();
        check("t4_v0_mask", v0_mask_data, VLEN'(16'hF0F0));
        mask_wr_en = 0;
        cycle();
        wdata = vb;
        cycle();
        wr_valid = 0;
        check("t4_wr_done", wr_done, 1);
        check("t4_v0_final", v0_mask_data, va);
        cycle();

        wr_valid = 1; wr_addr = 4; wr_lmul = 0; wdata = VLEN'(8'hAB);
        rd_req_valid = 1; rd_addr1 = 4; rd_addr2 = 5; rd_lmul = 0;
        cycle();
        wr_valid = 0; rd_req_valid = 0;
`ifdef RD_BYPASS_EN
        vexp = VLEN'(8'hAB);
`else
        vexp = '0;
`endif
        check("t5_collision", rdata_1, vexp);
        cycle();

        rd_req_valid = 1; rd_addr1 = 0; rd_addr2 = 8; rd_lmul = 3;
        wr_valid = 1; wr_addr = 16; wr_lmul = 3; wdata = rand_vec();
        cycle();
        rd_req_valid = 0;
        wdata = rand_vec();
        cycle();
        wdata = rand_vec();
        cycle();
        check("t6_beat_before_reset", rd_beat, 2);
        rst_n = 0;
        idle_inputs();
        model_reset();
        #1 check_reset_outputs("t6_midburst");
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("t6_held");
        rst_n = 1;
        for (int g = 0; g < 4; g++) begin
            rd_req_valid = 1; rd_addr1 = ADDR_WIDTH'(8 * g); rd_addr2 = ADDR_WIDTH'(8 * g); rd_lmul = 3;
            cycle();
            rd_req_valid = 0;
            check("t6_zero_readback", rdata_1, 0);
            repeat (8) cycle();
        end

        repeat (1500) begin
            rd_lmul = 2'($urandom_range(0, 3));
            rand_addr(rd_addr1, rd_lmul);
            rand_addr(rd_addr2, rd_lmul);
            rd_req_valid = ($urandom_range(0, 2) == 0);
            wr_lmul = 2'($urandom_range(0, 3));
            rand_addr(wr_addr, wr_lmul);
            wr_valid = ($urandom_range(0, 9) < 7);
            wdata = rand_vec();
            mask_wr_en = ($urandom_range(0, 19) == 0);
            mask_wdata = rand_vec();
            cycle();
        end
        idle_inputs();
        repeat (12) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
